// File: rtl/rf_bank_fill_ctrl.sv
// Write-side fill controller for the banked register file: packs a valid/ready beat stream
// into free banks round-robin. Optional zero-pad flush of a partial bank under RF_FILL_FLUSH_EN.
module rf_bank_fill_ctrl #(
  parameter int DATA_W     = 4,
  parameter int NUM_BANKS  = 3,
  parameter int BANK_DEPTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [1:0]           w_bank,
  output logic [2:0]           w_addr,
  output logic [DATA_W-1:0]    w_data,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic                 all_full,
`ifdef RF_FILL_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 rel_valid,
  input  logic [1:0]           rel_bank
);

  // state | meaning
  // FILL  | accepting beats into cur_bank at addr
  // NEXT  | bank just closed; pick the next free bank (cur_bank counts as full)
  // STALL | every bank full; wait for a release
  // PAD   | flush: write zeros to the remaining addresses of cur_bank
`ifdef RF_FILL_FLUSH_EN
  typedef enum logic [1:0] {FILL, NEXT, STALL, PAD} state_t;
`else
  typedef enum logic [1:0] {FILL, NEXT, STALL} state_t;
`endif

  localparam logic [1:0] NO_WRITE = 2'b11;
  localparam logic [2:0] LAST_ADDR = 3'(BANK_DEPTH - 1);

  state_t               state;
  logic [1:0]           cur_bank;
  logic [2:0]           addr;

  logic                 accept;
  logic                 at_last;
  logic                 done;
  logic [NUM_BANKS-1:0] set_vec;
  logic [NUM_BANKS-1:0] rel_clr;
  logic [NUM_BANKS-1:0] srch_mask;
  logic                 srch_found;
  logic [1:0]           srch_bank;
  int                   srch_idx;

  assign in_ready = (state == FILL) && !rst;
  assign all_full = &bank_full;

  always_comb begin
    accept  = in_valid && in_ready;
    at_last = (addr == LAST_ADDR);
`ifdef RF_FILL_FLUSH_EN
    done    = ((state == FILL) && accept && at_last) || ((state == PAD) && at_last);
`else
    done    = (state == FILL) && accept && at_last;
`endif
    set_vec   = '0;
    rel_clr   = '0;
    srch_mask = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      set_vec[b]   = done && (cur_bank == 2'(b));
      // the bank being closed in NEXT already shows full but may not be released yet
      rel_clr[b]   = rel_valid && (rel_bank == 2'(b)) && bank_full[b] &&
                     !((state == NEXT) && (cur_bank == 2'(b)));
      srch_mask[b] = bank_full[b] || ((state == NEXT) && (cur_bank == 2'(b)));
    end
    srch_found = 1'b0;
    srch_bank  = cur_bank;
    srch_idx   = 0;
    for (int i = 1; i <= NUM_BANKS; i++) begin
      srch_idx = (int'(cur_bank) + i) % NUM_BANKS;
      if (!srch_found && !srch_mask[srch_idx]) begin
        srch_found = 1'b1;
        srch_bank  = 2'(srch_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cur_bank  <= 2'd0;
      addr      <= 3'd0;
      bank_full <= '0;
      w_bank    <= NO_WRITE;
      w_addr    <= 3'd0;
      w_data    <= '0;
    end else begin
      w_bank    <= NO_WRITE;
      bank_full <= (bank_full & ~rel_clr) | set_vec;
      case (state)
        FILL: begin
          if (accept) begin
            w_bank <= cur_bank;
            w_addr <= addr;
            w_data <= in_data;
            if (at_last) begin
              addr  <= 3'd0;
              state <= NEXT;
            end else begin
              addr <= addr + 3'd1;
            end
          end
`ifdef RF_FILL_FLUSH_EN
          if (flush && (addr != 3'd0) && !(accept && at_last))
            state <= PAD;
`endif
        end
`ifdef RF_FILL_FLUSH_EN
        PAD: begin
          w_bank <= cur_bank;
          w_addr <= addr;
          w_data <= '0;
          if (at_last) begin
            addr  <= 3'd0;
            state <= NEXT;
          end else begin
            addr <= addr + 3'd1;
          end
        end
`endif
        NEXT, STALL: begin
          if (srch_found) begin
            cur_bank <= srch_bank;
            state    <= FILL;
          end else begin
            state <= STALL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
